div_req_sched: RTL and testbench

- Arbitrates between two requesters that each submit a DATA_W-bit word for divisibility checking.
- Serialises the granted word MSB-first into the shared bit-serial divisibility checker.
- Waits for the checker's result and returns it to the owning requester.
- Control and status are exposed on the register bus, alongside the existing counter register.

---
 rtl/div_req_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_div_req_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_sched.sv
// div_req_sched: two-requester scheduler for a shared bit-serial divisibility
// checker. Arbitrates, streams the granted word MSB-first, waits (bounded)
// for the checker result and returns it to the owner. CTRL/STAT registers.

`ifndef REG_ADDR_SZ
`define REG_ADDR_SZ 8
`endif
`ifndef REG_DATA_SZ
`define REG_DATA_SZ 16
`endif

module div_req_sched #(
  parameter int                      DATA_W    = 8,
  parameter int                      TIMEOUT   = 16,
  parameter logic [`REG_ADDR_SZ-1:0] CTRL_ADDR = `REG_ADDR_SZ'h06,
  parameter logic [`REG_ADDR_SZ-1:0] STAT_ADDR = `REG_ADDR_SZ'h07
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_vld,
  input  logic [DATA_W-1:0]        req_data_0,
  input  logic [DATA_W-1:0]        req_data_1,
  output logic [1:0]               req_rdy,
  output logic [1:0]               rsp_vld,
  output logic                     rsp_divisible,
  output logic                     rsp_err,
  output logic                     chk_clr,
  output logic                     chk_bit,
  output logic                     chk_bit_vld,
  input  logic                     chk_divisible,
  input  logic                     chk_result_vld,
  input  logic                     reg_rd_en,
  input  logic                     reg_wr_en,
  input  logic [`REG_ADDR_SZ-1:0]  reg_addr,
  input  logic [`REG_DATA_SZ-1:0]  reg_wr_data,
  output logic [`REG_DATA_SZ-1:0]  reg_rd_data
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t              state_r;
  logic                ctrl_en_r;
  logic                ctrl_mode_r;
  logic                stat_to_r;
  logic [7:0]          done_cnt_r;
  logic                last_gnt_r;
  logic                owner_r;
  logic [DATA_W-1:0]   shreg_r;
  logic [BW-1:0]       bit_cnt_r;
  logic [TW-1:0]       wait_cnt_r;
  logic [1:0]          rsp_vld_r;
  logic                rsp_div_r;
  logic                rsp_err_r;
  logic                chk_clr_r;
  logic                chk_bit_r;
  logic                chk_bit_vld_r;

  logic                win_s;
  logic [1:0]          gnt_s;
  logic                ctrl_wr_s;
  logic                stat_clr_s;
  logic                to_set_s;
  logic [`REG_DATA_SZ-1:0] rd_s;
  logic                unused_wr_bits_s;

  assign unused_wr_bits_s = ^reg_wr_data[`REG_DATA_SZ-1:2];

  // Arbitration: pick a winner and raise the combinational accept in IDLE only
  always_comb begin
    win_s = 1'b0;
    if (req_vld == 2'b11) begin
      if (ctrl_mode_r) begin
        win_s = 1'b0;
      end else begin
        win_s = ~last_gnt_r;
      end
    end else if (req_vld[0]) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
    if ((state_r == ST_IDLE) && ctrl_en_r && (req_vld != 2'b00)) begin
      gnt_s = win_s ? 2'b10 : 2'b01;
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Register write decode and timeout-expiry detection
  always_comb begin
    ctrl_wr_s  = reg_wr_en && (reg_addr == CTRL_ADDR);
    stat_clr_s = reg_wr_en && (reg_addr == STAT_ADDR) && reg_wr_data[0];
    to_set_s   = (state_r == ST_WAIT) && !chk_result_vld && (wait_cnt_r == WAIT_LAST);
  end

  // Register read mux, gated by read enable and an address hit
  always_comb begin
    rd_s = {`REG_DATA_SZ{1'b0}};
    if (reg_rd_en && (reg_addr == CTRL_ADDR)) begin
      rd_s[1:0] = {ctrl_mode_r, ctrl_en_r};
    end else if (reg_rd_en && (reg_addr == STAT_ADDR)) begin
      rd_s[15:8] = done_cnt_r;
      rd_s[0]    = stat_to_r;
    end else begin
      rd_s = {`REG_DATA_SZ{1'b0}};
    end
  end

  // CTRL/STAT state: sticky timeout (set beats W1C) and completed-transaction count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en_r   <= 1'b0;
      ctrl_mode_r <= 1'b0;
      stat_to_r   <= 1'b0;
      done_cnt_r  <= 8'd0;
    end else begin
      if (ctrl_wr_s) begin
        ctrl_en_r   <= reg_wr_data[0];
        ctrl_mode_r <= reg_wr_data[1];
      end
      if (to_set_s) begin
        stat_to_r <= 1'b1;
      end else if (stat_clr_s) begin
        stat_to_r <= 1'b0;
      end
      if (state_r == ST_RESP) begin
        done_cnt_r <= done_cnt_r + 8'd1;
      end
    end
  end

  // Transaction FSM with registered checker and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      last_gnt_r    <= 1'b1;
      owner_r       <= 1'b0;
      shreg_r       <= {DATA_W{1'b0}};
      bit_cnt_r     <= {BW{1'b0}};
      wait_cnt_r    <= {TW{1'b0}};
      rsp_vld_r     <= 2'b00;
      rsp_div_r     <= 1'b0;
      rsp_err_r     <= 1'b0;
      chk_clr_r     <= 1'b0;
      chk_bit_r     <= 1'b0;
      chk_bit_vld_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_s != 2'b00) begin
            shreg_r    <= win_s ? req_data_1 : req_data_0;
            owner_r    <= win_s;
            last_gnt_r <= win_s;
            chk_clr_r  <= 1'b1;
            state_r    <= ST_CLR;
          end
        end
        ST_CLR: begin
          chk_clr_r     <= 1'b0;
          chk_bit_vld_r <= 1'b1;
          chk_bit_r     <= shreg_r[DATA_W-1];
          shreg_r       <= {shreg_r[DATA_W-2:0], 1'b0};
          bit_cnt_r     <= {BW{1'b0}};
          state_r       <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_cnt_r == BIT_LAST) begin
            chk_bit_vld_r <= 1'b0;
            chk_bit_r     <= 1'b0;
            bit_cnt_r     <= {BW{1'b0}};
            wait_cnt_r    <= {TW{1'b0}};
            state_r       <= ST_WAIT;
          end else begin
            bit_cnt_r <= bit_cnt_r + BW'(1);
            chk_bit_r <= shreg_r[DATA_W-1];
            shreg_r   <= {shreg_r[DATA_W-2:0], 1'b0};
          end
        end
        ST_WAIT: begin
          if (chk_result_vld) begin
            rsp_vld_r <= owner_r ? 2'b10 : 2'b01;
            rsp_div_r <= chk_divisible;
            rsp_err_r <= 1'b0;
            state_r   <= ST_RESP;
          end else if (wait_cnt_r == WAIT_LAST) begin
            rsp_vld_r <= owner_r ? 2'b10 : 2'b01;
            rsp_div_r <= 1'b0;
            rsp_err_r <= 1'b1;
            state_r   <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
          end
        end
        ST_RESP: begin
          rsp_vld_r <= 2'b00;
          rsp_div_r <= 1'b0;
          rsp_err_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          rsp_vld_r     <= 2'b00;
          rsp_div_r     <= 1'b0;
          rsp_err_r     <= 1'b0;
          chk_clr_r     <= 1'b0;
          chk_bit_r     <= 1'b0;
          chk_bit_vld_r <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_rdy       = gnt_s;
  assign rsp_vld       = rsp_vld_r;
  assign rsp_divisible = rsp_div_r;
  assign rsp_err       = rsp_err_r;
  assign chk_clr       = chk_clr_r;
  assign chk_bit       = chk_bit_r;
  assign chk_bit_vld   = chk_bit_vld_r;
  assign reg_rd_data   = rd_s;

endmodule

// File: tb/tb_div_req_sched.sv
// Scoreboard bench for div_req_sched: stimulus pushes expected grants, shifted
// words and responses; independent monitors pop and compare. A behavioural
// divide-by-3 checker answers two cycles after the last serial bit.

`ifndef REG_ADDR_SZ
`define REG_ADDR_SZ 8
`endif
`ifndef REG_DATA_SZ
`define REG_DATA_SZ 16
`endif

module tb_div_req_sched;

  logic                    clk;
  logic                    rst;
  logic [1:0]              req_vld;
  logic [7:0]              req_data_0;
  logic [7:0]              req_data_1;
  logic [1:0]              req_rdy;
  logic [1:0]              rsp_vld;
  logic                    rsp_divisible;
  logic                    rsp_err;
  logic                    chk_clr;
  logic                    chk_bit;
  logic                    chk_bit_vld;
  logic                    chk_divisible;
  logic                    chk_result_vld;
  logic                    reg_rd_en;
  logic                    reg_wr_en;
  logic [`REG_ADDR_SZ-1:0] reg_addr;
  logic [`REG_DATA_SZ-1:0] reg_wr_data;
  logic [`REG_DATA_SZ-1:0] reg_rd_data;

  div_req_sched dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_data_0(req_data_0), .req_data_1(req_data_1),
    .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_divisible(rsp_divisible),
    .rsp_err(rsp_err), .chk_clr(chk_clr), .chk_bit(chk_bit),
    .chk_bit_vld(chk_bit_vld), .chk_divisible(chk_divisible),
    .chk_result_vld(chk_result_vld), .reg_rd_en(reg_rd_en),
    .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_data(reg_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] gnt_q[$];
  logic [7:0] word_q[$];
  logic [3:0] rsp_q[$];   // {rsp_vld, divisible, err}

  logic chk_en = 1'b1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic fail_now(input string nm, input logic [31:0] got);
    n_checks++;
    $display("FAIL %s: got %0h expected nothing", nm, got);
  endtask

  task automatic expect_txn(input logic owner, input logic [7:0] word, input logic dv, input logic er);
    gnt_q.push_back(owner ? 2'b10 : 2'b01);
    word_q.push_back(word);
    rsp_q.push_back({(owner ? 2'b10 : 2'b01), dv, er});
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    reg_wr_en = 1'b1; reg_addr = a; reg_wr_data = d;
    @(posedge clk); #1;
    reg_wr_en = 1'b0; reg_addr = 8'h00; reg_wr_data = 16'h0000;
  endtask

  task automatic reg_read(input logic [7:0] a, input logic [15:0] exp, input string nm);
    @(posedge clk); #1;
    reg_rd_en = 1'b1; reg_addr = a;
    #2;
    check(nm, reg_rd_data, exp);
    reg_rd_en = 1'b0; reg_addr = 8'h00;
  endtask

  // Returns just after the posedge that captured the n-th grant
  task automatic wait_grants(input int n, input int budget, input string nm);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (req_rdy != 2'b00) seen++;
    end
    if (seen < n) fail_now({nm, "_grant_bound"}, seen);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int cyc = 0;
    while ((rsp_q.size() != 0 || gnt_q.size() != 0) && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    if (rsp_q.size() != 0 || gnt_q.size() != 0) fail_now({nm, "_drain_bound"}, rsp_q.size());
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Grant monitor
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && req_rdy != 2'b00) begin
        if (gnt_q.size() == 0) fail_now("unexpected_grant", req_rdy);
        else begin
          e = gnt_q.pop_front();
          check("grant", req_rdy, e);
        end
      end
    end
  end

  // Serial word monitor
  initial begin
    logic [7:0] acc;
    int cnt;
    logic [7:0] e;
    acc = 8'h00; cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) cnt = 0;
      else begin
        if (chk_clr) begin cnt = 0; acc = 8'h00; end
        if (chk_bit_vld) begin
          acc = {acc[6:0], chk_bit};
          cnt++;
          if (cnt == 8) begin
            cnt = 0;
            if (word_q.size() == 0) fail_now("unexpected_word", acc);
            else begin
              e = word_q.pop_front();
              check("shift_word", acc, e);
            end
          end
        end
      end
    end
  end

  // Response monitor
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_vld != 2'b00) begin
        if (rsp_q.size() == 0) fail_now("unexpected_rsp", {rsp_vld, rsp_divisible, rsp_err});
        else begin
          e = rsp_q.pop_front();
          check("rsp", {rsp_vld, rsp_divisible, rsp_err}, e);
        end
      end
    end
  end

  // Behavioural divide-by-3 checker, answering 2 cycles after the last bit
  initial begin
    int rem, nb, cd;
    logic res;
    rem = 0; nb = 0; cd = 0; res = 1'b0;
    chk_result_vld = 1'b0; chk_divisible = 1'b0;
    forever begin
      @(negedge clk);
      chk_result_vld = 1'b0;
      chk_divisible  = 1'b0;
      if (rst) begin
        rem = 0; nb = 0; cd = 0;
      end else begin
        if (chk_clr) begin rem = 0; nb = 0; end
        if (chk_bit_vld) begin
          rem = (rem * 2 + int'(chk_bit)) % 3;
          nb++;
          if (nb == 8) begin cd = 2; res = (rem == 0); nb = 0; end
        end else if (cd > 0) begin
          cd--;
          if (cd == 0 && chk_en) begin
            chk_result_vld = 1'b1;
            chk_divisible  = res;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cnt;
    rst = 1'b1;
    req_vld = 2'b00; req_data_0 = 8'h00; req_data_1 = 8'h00;
    reg_rd_en = 1'b0; reg_wr_en = 1'b0; reg_addr = 8'h00; reg_wr_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {req_rdy, rsp_vld, rsp_divisible, rsp_err, chk_clr, chk_bit, chk_bit_vld}, 32'h0);
    rst = 1'b0;
    reg_read(8'h06, 16'h0000, "reset_ctrl");
    reg_read(8'h07, 16'h0000, "reset_stat");

    // Single request from requester 0: 0xA5 = 165, divisible by 3
    reg_write(8'h06, 16'h0001);
    expect_txn(1'b0, 8'hA5, 1'b1, 1'b0);
    req_data_0 = 8'hA5; req_vld = 2'b01;
    wait_grants(1, 50, "t1");
    req_vld = 2'b00;
    wait_drain(100, "t1");
    reg_read(8'h07, 16'h0100, "t1_stat_done1");

    // Timeout: checker silent, requester 1 with 0x09
    chk_en = 1'b0;
    expect_txn(1'b1, 8'h09, 1'b0, 1'b1);
    req_data_1 = 8'h09; req_vld = 2'b10;
    wait_grants(1, 50, "t4");
    req_vld = 2'b00;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rsp_vld == 2'b00 && cyc < 80);
    check("timeout_latency", cyc, 26);
    wait_drain(50, "t4");
    chk_en = 1'b1;
    reg_read(8'h07, 16'h0201, "t4_stat_timeout");
    reg_write(8'h07, 16'h0001);
    reg_read(8'h07, 16'h0200, "t4_stat_w1c");

    // Round-robin, both held valid: 0,1,0,1 (last grant was requester 1)
    req_data_0 = 8'h0C; req_data_1 = 8'h07;
    expect_txn(1'b0, 8'h0C, 1'b1, 1'b0);
    expect_txn(1'b1, 8'h07, 1'b0, 1'b0);
    expect_txn(1'b0, 8'h0C, 1'b1, 1'b0);
    expect_txn(1'b1, 8'h07, 1'b0, 1'b0);
    req_vld = 2'b11;
    wait_grants(4, 200, "t2");
    req_vld = 2'b00;
    wait_drain(100, "t2");

    // Fixed priority: three grants to 0, then 1 once req 0 drops
    reg_write(8'h06, 16'h0003);
    reg_read(8'h06, 16'h0003, "t3_ctrl");
    expect_txn(1'b0, 8'h0C, 1'b1, 1'b0);
    expect_txn(1'b0, 8'h0C, 1'b1, 1'b0);
    expect_txn(1'b0, 8'h0C, 1'b1, 1'b0);
    expect_txn(1'b1, 8'h07, 1'b0, 1'b0);
    req_vld = 2'b11;
    wait_grants(3, 200, "t3a");
    req_vld = 2'b10;
    wait_grants(1, 50, "t3b");
    req_vld = 2'b00;
    wait_drain(100, "t3");

    // Reset during bit 3 of the shift of 0x33 (bits 0,0,1,1,...)
    gnt_q.push_back(2'b01);
    req_data_0 = 8'h33; req_vld = 2'b01;
    wait_grants(1, 50, "t5");
    req_vld = 2'b00;
    repeat (5) @(negedge clk);
    check("pre_rst_bit3", {chk_bit_vld, chk_bit}, 2'b11);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {req_rdy, rsp_vld, rsp_divisible, rsp_err, chk_clr, chk_bit, chk_bit_vld}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reg_write(8'h06, 16'h0001);
    expect_txn(1'b1, 8'h1E, 1'b1, 1'b0);
    req_data_1 = 8'h1E; req_vld = 2'b10;
    wait_grants(1, 50, "t5b");
    req_vld = 2'b00;
    @(negedge clk);
    check("post_rst_clr", chk_clr, 1'b1);
    wait_drain(100, "t5b");
    reg_read(8'h07, 16'h0100, "t5_stat_after_rst");

    // Disabled: no grants
    reg_write(8'h06, 16'h0000);
    req_vld = 2'b11;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_rdy != 2'b00) cnt++;
    end
    check("disabled_no_rdy", cnt, 0);
    @(posedge clk); #1;
    req_vld = 2'b00;
    reg_read(8'h06, 16'h0000, "t6_ctrl");
    reg_read(8'h20, 16'h0000, "t6_unmapped");

    check("gnt_q_empty", gnt_q.size(), 0);
    check("word_q_empty", word_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
